// File: rtl/icache_responder_pkg.sv
// -----------------------------------------------------------------------------
// icache_responder_pkg
//
// Shared types for the instruction-cache responder slice.
//   word_t         : 32-bit machine word used on every data port.
//   icache_state_t : responder controller states.
//   icachef_t      : field view of an instruction byte address
//                    (tag / frame index / byte offset) for the default
//                    16-frame geometry.
//   splitAddr      : helper that casts a word into the icachef_t view.
// -----------------------------------------------------------------------------
package icache_responder_pkg;

    typedef logic [31:0] word_t;

    // Default geometry; the modules recompute these from their own ISETS.
    localparam int ISETS = 16;
    localparam int IDXW  = $clog2(ISETS);
    localparam int TAGW  = 30 - IDXW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } icache_state_t;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [IDXW-1:0] idx;
        logic [1:0]      bytoff;
    } icachef_t;

    function automatic icachef_t splitAddr(input word_t addr);
        return icachef_t'(addr);
    endfunction

endpackage

// File: rtl/icache_frames.sv
// -----------------------------------------------------------------------------
// icache_frames
//
// Direct-mapped frame store for the instruction cache: one valid bit, tag and
// data word per frame. Valid bits are reset; tags and data are not.
//
// Ports:
//   clk_i, rst_ni           clock / asynchronous active-low reset
//   rdIdx_i, rdTag_i        lookup address fields
//   rdHit_o, rdData_o       lookup result (combinational)
//   fillEn_i, fillIdx_i,
//   fillTag_i, fillData_i   write a frame and mark it valid
//   invAddrEn_i,
//   invAddrIdx_i,
//   invAddrTag_i            clear valid only if the stored tag matches
//   invIdxEn_i, invIdxIdx_i clear valid of one frame unconditionally
// -----------------------------------------------------------------------------
module icache_frames #(
    parameter  int ISETS = 16,
    localparam int IDXW  = $clog2(ISETS),
    localparam int TAGW  = 30 - IDXW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [IDXW-1:0] rdIdx_i,
    input  logic [TAGW-1:0] rdTag_i,
    output logic            rdHit_o,
    output logic [31:0]     rdData_o,
    input  logic            fillEn_i,
    input  logic [IDXW-1:0] fillIdx_i,
    input  logic [TAGW-1:0] fillTag_i,
    input  logic [31:0]     fillData_i,
    input  logic            invAddrEn_i,
    input  logic [IDXW-1:0] invAddrIdx_i,
    input  logic [TAGW-1:0] invAddrTag_i,
    input  logic            invIdxEn_i,
    input  logic [IDXW-1:0] invIdxIdx_i
);

    logic [ISETS-1:0] valid_q;
    logic [ISETS-1:0] valid_d;
    logic [TAGW-1:0]  tag_q  [ISETS];
    logic [31:0]      data_q [ISETS];

    assign rdHit_o  = valid_q[rdIdx_i] && (tag_q[rdIdx_i] == rdTag_i);
    assign rdData_o = data_q[rdIdx_i];

    // Invalidations are applied after the fill so a clear always wins; the
    // controller never fills and invalidates the same frame in one cycle.
    always_comb begin
        valid_d = valid_q;
        if (fillEn_i) begin
            valid_d[fillIdx_i] = 1'b1;
        end
        if (invAddrEn_i && (tag_q[invAddrIdx_i] == invAddrTag_i)) begin
            valid_d[invAddrIdx_i] = 1'b0;
        end
        if (invIdxEn_i) begin
            valid_d[invIdxIdx_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fillEn_i) begin
            tag_q[fillIdx_i]  <= fillTag_i;
            data_q[fillIdx_i] <= fillData_i;
        end
    end

endmodule

// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//
// Memory-side responder for the datapath cache interface. Instruction fetches
// are served from a direct-mapped read-only cache that refills from the memory
// controller on a miss. Data accesses pass straight through to the memory
// controller and invalidate any cached copy of a written word. A halt flushes
// every frame and then raises flushed until reset.
//
// Ports:
//   CLK, nRST                         clock / asynchronous active-low reset
//   halt                              datapath halt (level)
//   imemREN, imemaddr                 instruction fetch request
//   ihit, imemload                    instruction response
//   dmemREN, dmemWEN, dmemaddr,
//   dmemstore                         data request
//   dhit, dmemload                    data response
//   flushed                           flush complete (sticky)
//   iREN, iaddr, iwait, iload         memory-controller instruction port
//   dREN, dWEN, daddr, dstore,
//   dwait, dload                      memory-controller data port
// -----------------------------------------------------------------------------
module icache_responder #(
    parameter  int ISETS = 16,
    localparam int IDXW  = $clog2(ISETS),
    localparam int TAGW  = 30 - IDXW
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    import icache_responder_pkg::*;

    icache_state_t   state_q, state_d;
    logic [29:0]     missWord_q, missWord_d;
    logic [IDXW-1:0] flushCnt_q, flushCnt_d;

    logic            dreq;
    logic [IDXW-1:0] reqIdx;
    logic [TAGW-1:0] reqTag;
    logic [IDXW-1:0] dIdx;
    logic [TAGW-1:0] dTag;
    logic            lookupHit;
    word_t           frameData;
    logic            fillEn;
    logic            invIdxEn;
    logic            unusedByteOffset;

    assign unusedByteOffset = ^imemaddr[1:0];

    assign reqIdx = imemaddr[IDXW+1:2];
    assign reqTag = imemaddr[31:IDXW+2];
    assign dIdx   = dmemaddr[IDXW+1:2];
    assign dTag   = dmemaddr[31:IDXW+2];

    // Data side is a pure pass-through. When read and write are both raised
    // only the write reaches the memory controller.
    assign dreq     = dmemREN | dmemWEN;
    assign dREN     = dmemREN & ~dmemWEN;
    assign dWEN     = dmemWEN;
    assign daddr    = dmemaddr;
    assign dstore   = dmemstore;
    assign dhit     = dreq & ~dwait;
    assign dmemload = dload;

    assign flushed  = (state_q == DONE);

    icache_frames #(
        .ISETS(ISETS)
    ) u_frames (
        .clk_i        (CLK),
        .rst_ni       (nRST),
        .rdIdx_i      (reqIdx),
        .rdTag_i      (reqTag),
        .rdHit_o      (lookupHit),
        .rdData_o     (frameData),
        .fillEn_i     (fillEn),
        .fillIdx_i    (missWord_q[IDXW-1:0]),
        .fillTag_i    (missWord_q[29:IDXW]),
        .fillData_i   (iload),
        .invAddrEn_i  (dmemWEN & dhit),
        .invAddrIdx_i (dIdx),
        .invAddrTag_i (dTag),
        .invIdxEn_i   (invIdxEn),
        .invIdxIdx_i  (flushCnt_q)
    );

    // Controller. Any pending data request blocks instruction service, which
    // is also what keeps a fill and a write-invalidate off the same cycle.
    // In MISS the fill always completes; ihit is only raised if the datapath
    // is still asking for the same word and no halt is pending.
    always_comb begin
        state_d    = state_q;
        missWord_d = missWord_q;
        flushCnt_d = flushCnt_q;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        fillEn     = 1'b0;
        invIdxEn   = 1'b0;

        case (state_q)
            IDLE: begin
                if (imemREN && lookupHit && !dreq && !halt) begin
                    ihit     = 1'b1;
                    imemload = frameData;
                end
                if (halt) begin
                    state_d    = FLUSH;
                    flushCnt_d = '0;
                end else if (imemREN && !lookupHit && !dreq) begin
                    state_d    = MISS;
                    missWord_d = imemaddr[31:2];
                end
            end

            MISS: begin
                iREN = ~dreq;
                if (!dreq) begin
                    iaddr = {missWord_q, 2'b00};
                end
                if (!dreq && !iwait) begin
                    fillEn = 1'b1;
                    if (imemREN && (imemaddr[31:2] == missWord_q) && !halt) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
                    state_d    = halt ? FLUSH : IDLE;
                    flushCnt_d = '0;
                end
            end

            FLUSH: begin
                invIdxEn   = 1'b1;
                flushCnt_d = flushCnt_q + 1'b1;
                if (flushCnt_q == IDXW'(ISETS - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            missWord_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            missWord_q <= missWord_d;
            flushCnt_q <= flushCnt_d;
        end
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Memory-side responder for the datapath_cache_if protocol. It answers the pipelined datapath's instruction and data requests.
- Instructions are served from a direct-mapped, read-only instruction cache. On a miss the cache fills from the memory controller.
- Data accesses pass through to the memory controller with write-invalidate against the icache.
- On halt, the block invalidates every frame and then raises flushed.

Parameters:
- ISETS, 16: number of direct-mapped icache frames; power of two, 2..64.
- IDXW, $clog2(ISETS): index width.
- TAGW, 30-IDXW: tag width.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- halt  in  1  datapath halt; level, sticky until reset
- imemREN  in  1  instruction read request
- imemaddr  in  32  instruction byte address; bits [1:0] ignored
- ihit  out  1  instruction valid this cycle
- imemload  out  32  instruction word
- dmemREN  in  1  data read request
- dmemWEN  in  1  data write request
- dmemaddr  in  32  data byte address
- dmemstore  in  32  data write value
- dhit  out  1  data access complete this cycle
- dmemload  out  32  data read value
- flushed  out  1  flush complete; sticky
- iREN  out  1  memory-controller instruction read
- iaddr  out  32  memory-controller instruction address
- iwait  in  1  memory-controller instruction busy
- iload  in  32  memory-controller instruction data
- dREN  out  1  memory-controller data read
- dWEN  out  1  memory-controller data write
- daddr  out  32  memory-controller data address
- dstore  out  32  memory-controller data store
- dwait  in  1  memory-controller data busy
- dload  in  32  memory-controller data read value

Behaviour:
- Address split: index = imemaddr[IDXW+1:2]; tag = imemaddr[31:IDXW+2].
- Frame storage: valid[ISETS], tag[ISETS][TAGW], data[ISETS][32].
- Reset: all valid cleared, state IDLE, flushed=0. Every output is 0 during and after reset until a request arrives. Tag/data arrays are not reset.
- dreq = dmemREN | dmemWEN. Data takes priority over instruction service.
- Data path is combinational pass-through:
  - dREN=dmemREN, dWEN=dmemWEN, daddr=dmemaddr, dstore=dmemstore.
  - dhit = dreq & ~dwait; dmemload = dload.
  - If dmemREN and dmemWEN are both asserted, only the write is forwarded (dREN=0).
- Write-invalidate: in the cycle a write completes (dmemWEN & dhit), a frame whose index and tag match dmemaddr has its valid bit cleared at the clock edge.
- States: IDLE, MISS, FLUSH, DONE.
- IDLE:
  - hit = imemREN & valid[idx] & tag match.
  - ihit = hit & ~dreq, with imemload = data[idx]. This is same-cycle, zero-latency.
  - A miss with ~dreq goes to MISS; the miss address is latched at entry.
  - halt goes to FLUSH and takes priority over a new miss.
- MISS:
  - iREN = ~dreq; iaddr = latched address.
  - When iREN=1 and iwait=0: write the frame (valid=1, tag, data=iload), drive ihit=1 and imemload=iload that same cycle, and return to IDLE.
  - If the datapath changes imemaddr mid-miss (branch redirect), complete the in-flight fill, suppress ihit for it, and return to IDLE. The new address is then looked up normally.
  - A dreq in MISS holds iREN low; the fill resumes after dreq drops.
  - halt in MISS: finish the current fill without ihit, then go to FLUSH.
- FLUSH:
  - A counter clears valid[cnt], one frame per cycle, from 0 to ISETS-1. Takes exactly ISETS cycles.
  - ihit=0 and iREN=0 throughout.
  - Data accesses are still serviced.
  - Go to DONE when cnt wraps.
- DONE: flushed=1, ihit=0. The block stays in DONE until reset.
- Reset mid-fill or mid-flush: asynchronous return to IDLE, all valid=0, counter=0.
- Invariant: ihit and the invalidate never target the same frame in the same cycle, because the data priority rule prevents it.

Decomposition:
- cpu_types_pkg (existing) supplies word_t.
- New package entries: icache_state_t enum {IDLE, MISS, FLUSH, DONE} and an icachef_t struct {tag, idx, bytoff}, parameterised via the IDXW constant.
- One sub-module, icache_frames: the valid/tag/data array with a read port, a fill port, an invalidate-by-address port and an invalidate-by-index port. The FSM lives in icache_responder.

Test Plan:
- Cold miss: imemREN, imemaddr=0x40, iwait=1 for 3 cycles then 0 with iload=0x8C220004 -> iREN high for 4 cycles, ihit=1 with imemload=0x8C220004 in cycle 4. A repeat access to 0x40 gives ihit same cycle with iREN=0.
- Conflict: after 0x40 is cached, fetch 0x80 (same index, ISETS=16) -> miss refill. A following 0x40 misses again.
- Data priority: icache miss pending while dmemREN=1 at 0x100, dwait low after 2 cycles, dload=0xDEADBEEF -> iREN=0 and ihit=0 throughout. dhit=1 with dmemload=0xDEADBEEF, then the fill resumes.
- Write-invalidate: cache 0x40, then dmemWEN at 0x40 with dstore=0x1 completes -> the next fetch of 0x40 misses.
- Halt: raise halt in IDLE -> ihit=0 for 16 cycles, then flushed=1 permanently. All frames miss after reset plus refetch.
- Reset mid-miss: nRST low while in MISS with iwait=1 -> iREN=0, ihit=0 and flushed=0 immediately. Fetch of a previously cached address misses.
